// File: rtl/voltage_frame_pkg.sv
// Shared definitions for the voltage frame transmitter.
//   state_t      : frame FSM state encoding
//   ASCII_*      : fixed characters of a text line
//   LINE_LEN     : bytes per channel line ("Ccc=d.dddV\r\n")
package voltage_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CONV,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_C   = 8'h43;
  localparam logic [7:0] ASCII_EQ  = 8'h3D;
  localparam logic [7:0] ASCII_DOT = 8'h2E;
  localparam logic [7:0] ASCII_V   = 8'h56;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_0   = 8'h30;

  localparam int LINE_LEN = 12;

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: VAL_W-bit binary to four BCD digits.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   start      : one-cycle pulse, captures bin
//   bin        : binary input (must be <= 9999 for a meaningful result)
//   bcd        : {thousands, hundreds, tens, units}, held until next start
//   done       : one-cycle pulse when bcd is valid, VAL_W+1 cycles after start
module bin2bcd #(
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic [15:0]      bcd,
  output logic             done
);

  localparam int CNT_W = $clog2(VAL_W + 2);

  logic [VAL_W-1:0] bin_p0;
  logic [15:0]      acc_p0;
  logic [15:0]      adj;
  logic [CNT_W-1:0] cnt;
  logic             run;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  always_comb begin
    adj = acc_p0;
    for (int i = 0; i < 4; i++) begin
      if (acc_p0[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_p0[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        cnt <= CNT_W'(VAL_W + 1);
      end else if (run) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Shift stage: one adjust+shift step per cycle for VAL_W cycles, then publish.
  always_ff @(posedge clk) begin
    if (start) begin
      bin_p0 <= bin;
      acc_p0 <= '0;
    end else if (run && cnt > CNT_W'(1)) begin
      acc_p0 <= {adj[14:0], bin_p0[VAL_W-1]};
      bin_p0 <= {bin_p0[VAL_W-2:0], 1'b0};
    end
    if (run && cnt == CNT_W'(1)) bcd <= acc_p0;
  end

endmodule

// File: rtl/voltage_frame_tx.sv
// Formats all channel millivolt readings as ASCII lines "Ccc=d.dddV\r\n" and
// writes them byte by byte into the UART TX FIFO.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   start       : one-cycle pulse, begins a frame (ignored while busy/done)
//   ch_addr     : channel being read from the value bank
//   ch_mv       : millivolt value of ch_addr, valid one cycle after ch_addr
//   tx_full     : FIFO full, write is withheld while high
//   wr_uart     : FIFO write strobe
//   w_data      : byte presented to the FIFO
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last byte has been accepted
module voltage_frame_tx
  import voltage_frame_pkg::*;
#(
  parameter int N_CH   = 13,
  parameter int CH_W   = 4,
  parameter int VAL_W  = 14,
  parameter int MAX_MV = 9999
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [CH_W-1:0] ch_addr,
  input  logic [VAL_W-1:0] ch_mv,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [7:0]      w_data,
  output logic            busy,
  output logic            frame_done
);

  state_t          state, state_nx;
  logic [CH_W-1:0] ch_addr_nx;
  logic [3:0]      idx, idx_nx;
  logic            fetch_wait, fetch_wait_nx;
  logic            conv_start;
  logic [VAL_W-1:0] conv_in;
  logic [15:0]     bcd;
  logic            conv_done;
  logic [7:0]      line_byte;

  function automatic logic [VAL_W-1:0] sat_mv(input logic [VAL_W-1:0] v);
    if (v > VAL_W'(MAX_MV)) return VAL_W'(MAX_MV);
    return v;
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] d);
    return ASCII_0 + {4'b0, d};
  endfunction

  function automatic logic [7:0] ch_tens(input logic [CH_W-1:0] c);
    return ASCII_0 + 8'(int'(c) / 10);
  endfunction

  function automatic logic [7:0] ch_units(input logic [CH_W-1:0] c);
    return ASCII_0 + 8'(int'(c) % 10);
  endfunction

  bin2bcd #(.VAL_W(VAL_W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_in),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_comb begin
    case (idx)
      4'd0:    line_byte = ASCII_C;
      4'd1:    line_byte = ch_tens(ch_addr);
      4'd2:    line_byte = ch_units(ch_addr);
      4'd3:    line_byte = ASCII_EQ;
      4'd4:    line_byte = digit(bcd[15:12]);
      4'd5:    line_byte = ASCII_DOT;
      4'd6:    line_byte = digit(bcd[11:8]);
      4'd7:    line_byte = digit(bcd[7:4]);
      4'd8:    line_byte = digit(bcd[3:0]);
      4'd9:    line_byte = ASCII_V;
      4'd10:   line_byte = ASCII_CR;
      4'd11:   line_byte = ASCII_LF;
      default: line_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nx      = state;
    ch_addr_nx    = ch_addr;
    idx_nx        = idx;
    fetch_wait_nx = fetch_wait;
    busy          = 1'b0;
    wr_uart       = 1'b0;
    w_data        = 8'h00;
    frame_done    = 1'b0;
    conv_start    = 1'b0;
    conv_in       = sat_mv(ch_mv);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx      = ST_FETCH;
          ch_addr_nx    = '0;
          fetch_wait_nx = 1'b1;
        end
      end
      ST_FETCH: begin
        busy = 1'b1;
        // First cycle lets the value bank follow the new ch_addr.
        if (fetch_wait) begin
          fetch_wait_nx = 1'b0;
        end else begin
          conv_start = 1'b1;
          state_nx   = ST_CONV;
        end
      end
      ST_CONV: begin
        busy = 1'b1;
        if (conv_done) begin
          state_nx = ST_SEND;
          idx_nx   = '0;
        end
      end
      ST_SEND: begin
        busy    = 1'b1;
        w_data  = line_byte;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          if (idx == 4'(LINE_LEN - 1)) begin
            idx_nx = '0;
            if (ch_addr == CH_W'(N_CH - 1)) begin
              state_nx = ST_DONE;
            end else begin
              ch_addr_nx    = ch_addr + 1'b1;
              fetch_wait_nx = 1'b1;
              state_nx      = ST_FETCH;
            end
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ch_addr    <= '0;
      idx        <= '0;
      fetch_wait <= 1'b0;
    end else begin
      state      <= state_nx;
      ch_addr    <= ch_addr_nx;
      idx        <= idx_nx;
      fetch_wait <= fetch_wait_nx;
    end
  end

endmodule

// File: tb/tb_voltage_frame_tx.sv
module tb_voltage_frame_tx;

  localparam int N_CH      = 13;
  localparam int CH_W      = 4;
  localparam int VAL_W     = 14;
  localparam int FRAME_LEN = 156;
  localparam int BUDGET    = 4000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CH_W-1:0]  ch_addr;
  logic [VAL_W-1:0] ch_mv;
  logic             tx_full;
  logic             wr_uart;
  logic [7:0]       w_data;
  logic             busy;
  logic             frame_done;

  always #5 clk = ~clk;

  voltage_frame_tx #(.N_CH(N_CH), .CH_W(CH_W), .VAL_W(VAL_W), .MAX_MV(9999)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ch_addr    (ch_addr),
    .ch_mv      (ch_mv),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Channel value bank: registered read, one cycle behind ch_addr.
  logic [VAL_W-1:0] mv_tab [0:15];
  always @(posedge clk) ch_mv <= mv_tab[ch_addr];

  // FIFO-side monitor.
  logic [7:0] cap[$];
  int   done_cnt  = 0;
  int   full_viol = 0;
  int   stab_viol = 0;
  logic prev_full = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (wr_uart === 1'b1) cap.push_back(w_data);
    if (wr_uart === 1'b1 && tx_full === 1'b1) full_viol++;
    if (prev_full && prev_data != 8'h00 && busy === 1'b1 && w_data !== prev_data) stab_viol++;
    prev_full = tx_full;
    prev_data = w_data;
    if (frame_done === 1'b1) done_cnt++;
  end

  bit stall_en = 1'b0;
  initial begin
    tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic string line_str(input int c, input int mv);
    int v;
    v = (mv > 9999) ? 9999 : mv;
    return $sformatf("C%02d=%0d.%03dV%c%c", c, v / 1000, v % 1000, 8'd13, 8'd10);
  endfunction

  task automatic chk_bytes(input string name, input int base, input string exp);
    int bad_i;
    int act_v;
    int exp_v;
    bad_i = -1;
    act_v = 0;
    exp_v = 0;
    for (int i = 0; i < exp.len(); i++) begin
      if (bad_i < 0) begin
        if (base + i >= cap.size()) begin
          bad_i = i; act_v = -1; exp_v = int'(exp[i]);
        end else if (cap[base + i] != exp[i]) begin
          bad_i = i; act_v = int'(cap[base + i]); exp_v = int'(exp[i]);
        end
      end
    end
    if (bad_i >= 0) $display("FAIL %s: byte %0d got 0x%02h, expected 0x%02h", name, bad_i, act_v, exp_v);
    total_cnt++;
    if (bad_i < 0) pass_cnt++;
  endtask

  task automatic chk_frame(input string name, input int base);
    string exp;
    exp = "";
    for (int c = 0; c < N_CH; c++) exp = {exp, line_str(c, int'(mv_tab[c]))};
    chk_bytes(name, base, exp);
  endtask

  task automatic run_frame(input bit mid_start, input bit done_start,
                           output int base, output int d0, output bit tmo);
    int n;
    base = cap.size();
    d0   = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (frame_done !== 1'b1 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
      if (mid_start && n == 100) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n++;
      end
    end
    tmo = (n >= BUDGET);
    if (!tmo && done_start) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame_basic(input string tag, input bit tmo, input int base, input int d0);
    chk({tag, "_timeout"}, !tmo, int'(tmo), 0);
    chk({tag, "_bytes"}, cap.size() - base == FRAME_LEN, cap.size() - base, FRAME_LEN);
    chk({tag, "_done_pulses"}, done_cnt - d0 == 1, done_cnt - d0, 1);
    chk({tag, "_busy_after"}, busy === 1'b0, int'(busy), 0);
  endtask

  typedef struct {
    int    ch;
    int    mv;
    string exp;
  } line_vec_t;

  line_vec_t tab_b [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, d0, bad, keep, n, fv0, sv0;
    bit tmo;

    tab_b[0] = '{12, 12000, "C12=9.999V\015\012"};
    tab_b[1] = '{3,  9999,  "C03=9.999V\015\012"};
    tab_b[2] = '{1,  16383, "C01=9.999V\015\012"};
    tab_b[3] = '{9,  1000,  "C09=1.000V\015\012"};
    tab_b[4] = '{10, 999,   "C10=0.999V\015\012"};
    tab_b[5] = '{7,  5,     "C07=0.005V\015\012"};

    for (int i = 0; i < 16; i++) mv_tab[i] = '0;
    reset = 1'b0;
    start = 1'b1;

    // Reset held with start asserted.
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || wr_uart !== 1'b0 || ch_addr !== '0 || frame_done !== 1'b0) bad++;
    end
    chk("reset_busy", busy === 1'b0, int'(busy), 0);
    chk("reset_wr_uart", wr_uart === 1'b0, int'(wr_uart), 0);
    chk("reset_ch_addr", ch_addr === '0, int'(ch_addr), 0);
    chk("reset_w_data", w_data === 8'h00, int'(w_data), 0);
    chk("reset_hold_cycles_bad", bad == 0, bad, 0);
    chk("reset_no_frame_done", done_cnt == 0, done_cnt, 0);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame A: only channel 5 non-zero.
    mv_tab[5] = 14'd1234;
    run_frame(1'b0, 1'b0, base, d0, tmo);
    frame_basic("frameA", tmo, base, d0);
    chk_bytes("frameA_line5", base + 60, "C05=1.234V\015\012");
    chk_bytes("frameA_line0", base, "C00=0.000V\015\012");
    chk_frame("frameA_all", base);

    // Frame B: saturation and digit patterns from the table.
    for (int i = 0; i < 16; i++) mv_tab[i] = '0;
    foreach (tab_b[i]) mv_tab[tab_b[i].ch] = VAL_W'(tab_b[i].mv);
    run_frame(1'b0, 1'b0, base, d0, tmo);
    frame_basic("frameB", tmo, base, d0);
    foreach (tab_b[i])
      chk_bytes($sformatf("frameB_line%0d", tab_b[i].ch), base + tab_b[i].ch * 12, tab_b[i].exp);
    chk_frame("frameB_all", base);

    // Frame B again with random FIFO back-pressure.
    fv0 = full_viol;
    sv0 = stab_viol;
    stall_en = 1'b1;
    run_frame(1'b0, 1'b0, base, d0, tmo);
    stall_en = 1'b0;
    frame_basic("stall", tmo, base, d0);
    chk_frame("stall_all", base);
    chk("stall_write_while_full", full_viol == fv0, full_viol - fv0, 0);
    chk("stall_w_data_changed", stab_viol == sv0, stab_viol - sv0, 0);

    // Start mid-frame and start during the DONE cycle are both ignored.
    for (int i = 0; i < 16; i++) mv_tab[i] = '0;
    mv_tab[5] = 14'd1234;
    run_frame(1'b1, 1'b1, base, d0, tmo);
    frame_basic("restart", tmo, base, d0);
    chk_frame("restart_all", base);
    repeat (5) @(posedge clk);
    #1;
    chk("restart_no_extra_bytes", cap.size() - base == FRAME_LEN, cap.size() - base, FRAME_LEN);

    // Reset in the middle of a frame.
    base = cap.size();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (cap.size() - base < 40 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midreset_reach_byte40", n < BUDGET, n, BUDGET);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_wr_uart", wr_uart === 1'b0, int'(wr_uart), 0);
    chk("midreset_busy", busy === 1'b0, int'(busy), 0);
    chk("midreset_ch_addr", ch_addr === '0, int'(ch_addr), 0);
    keep = cap.size();
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_no_more_bytes", cap.size() == keep, cap.size() - keep, 0);
    chk("midreset_busy_idle", busy === 1'b0, int'(busy), 0);

    run_frame(1'b0, 1'b0, base, d0, tmo);
    frame_basic("after_reset", tmo, base, d0);
    chk_bytes("after_reset_line0", base, "C00=0.000V\015\012");
    chk_frame("after_reset_all", base);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/voltage_frame_tx.md
Name: voltage_frame_tx

Overview:
Formats a snapshot of all analog channel readings (millivolts) into ASCII text lines and pushes the bytes, one per clock at most, into the UART transmit FIFO through its wr_uart/w_data/tx_full write port. It sits directly upstream of the uart block and downstream of the channel-value register bank. One start pulse sends one full frame; the block reads channel values itself through a small address/data read port.

Parameters:
N_CH, 13, number of channels per frame
CH_W, 4, width of channel address
VAL_W, 14, width of millivolt value input
MAX_MV, 9999, saturation limit for displayed value

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse: begin a frame
ch_addr  out  CH_W  channel being read
ch_mv  in  VAL_W  millivolt value of ch_addr, valid one cycle after ch_addr changes
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  FIFO write strobe
w_data  out  8  byte to FIFO
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, ch_addr=0, busy=0, frame_done=0, wr_uart=0, w_data=0x00, byte index 0. Reset mid-frame aborts immediately; bytes already written stay in FIFO, no flush.
- Line format per channel c (12 bytes): 'C', tens(c), units(c), '=', d3, '.', d2, d1, d0, 'V', 0x0D, 0x0A; digits ASCII '0'+n. Channel printed decimal 00..12. Frame = N_CH lines, channel 0 first, 156 bytes total by default.
- Value: v = min(ch_mv, MAX_MV); d3..d0 = decimal digits of v (1234 -> "1.234").
- FSM:
  IDLE: busy=0; start=1 -> FETCH, ch_addr=0, busy=1.
  FETCH: one wait cycle, then latch ch_mv (saturated) and start converter -> CONV.
  CONV: wait for converter done (fixed VAL_W+2 = 16 cycles) -> SEND, byte index 0.
  SEND: byte presented combinationally on w_data; wr_uart = ~tx_full (combinational); index advances only when wr_uart=1. After index 11 accepted: if ch_addr==N_CH-1 -> DONE, else ch_addr+1 -> FETCH.
  DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Handshake: never asserts wr_uart while tx_full=1; at most one write per cycle; a byte is written exactly once. tx_full held high stalls indefinitely with w_data stable.
- start while busy ignored (no restart, no queuing). start in the same cycle DONE is active ignored.
- ch_addr held constant from FETCH through end of SEND for that channel.

Decomposition:
- Package voltage_frame_pkg: FSM state encoding, ASCII constants ('C','=','.','V',CR,LF,'0'), LINE_LEN=12.
- Sub-module bin2bcd: sequential double-dabble, VAL_W-bit binary in, 4 BCD digits out, start/done, fixed latency, same clk and active-low synchronous reset.

Test Plan:
- Reset held low 3 cycles with start=1 -> busy=0, wr_uart=0, ch_addr=0, frame_done never pulses.
- start, tx_full=0, ch5=1234, all others 0 -> exactly 156 writes; bytes 60..71 = "C05=1.234V\r\n"; channel 0 line "C00=0.000V\r\n"; one frame_done pulse.
- ch12=12000 and ch3=9999 -> line 12 "C12=9.999V\r\n", line 3 "C03=9.999V\r\n".
- tx_full toggled randomly 50% during frame -> no wr_uart while tx_full=1, byte stream identical to unstalled run, w_data stable across stalls.
- Second start pulse mid-frame -> ignored; total 156 bytes, single frame_done.
- reset low during byte 40 -> wr_uart=0 next cycle, busy=0; new start afterwards produces full correct 156-byte frame starting "C00=".
